// File: rtl/reg_bank_ctrl.sv
// Sequencer sharing one 16x8 register bank between NREQ requesters: one write or dual read per 3 cycles.
// Optional RBC_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin arbitration.
module reg_bank_ctrl #(
    parameter int NREQ = 2,
    parameter int AW   = 4,
    parameter int DW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_waddr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic [NREQ*AW-1:0] req_raddr1,
    input  logic [NREQ*AW-1:0] req_raddr2,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [DW-1:0]     rdata1,
    output logic [DW-1:0]     rdata2,
    output logic              busy,
    output logic              rb_w_r,
    output logic [AW-1:0]     rb_w_add,
    output logic [AW-1:0]     rb_r_add_1,
    output logic [AW-1:0]     rb_r_add_2,
    output logic [DW-1:0]     rb_data,
    input  logic [DW-1:0]     rb_data_1,
    input  logic [DW-1:0]     rb_data_2
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   owner_q;
    logic            we_q;
    logic [AW-1:0]   waddr_q;
    logic [DW-1:0]   wdata_q;
    logic [AW-1:0]   raddr1_q;
    logic [AW-1:0]   raddr2_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic [DW-1:0]   rdata1_q;
    logic [DW-1:0]   rdata2_q;
    logic            busy_q;
    logic            rb_w_r_q;
    logic [AW-1:0]   rb_w_add_q;
    logic [AW-1:0]   rb_r_add_1_q;
    logic [AW-1:0]   rb_r_add_2_q;
    logic [DW-1:0]   rb_data_q;

    logic            found_d;
    logic [IW-1:0]   win_d;

`ifdef RBC_FIXED_PRIO_EN
    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found_d && req[i]) begin
                found_d = 1'b1;
                win_d   = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] rr_q;
    int unsigned   idx;

    // Search starts just after the last winner so every requester is reached within NREQ grants.
    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(rr_q) + 1 + i) % NREQ;
            if (!found_d && req[idx]) begin
                found_d = 1'b1;
                win_d   = IW'(idx);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            raddr1_q     <= '0;
            raddr2_q     <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            rdata1_q     <= '0;
            rdata2_q     <= '0;
            busy_q       <= 1'b0;
            rb_w_r_q     <= 1'b0;
            rb_w_add_q   <= '0;
            rb_r_add_1_q <= '0;
            rb_r_add_2_q <= '0;
            rb_data_q    <= '0;
`ifndef RBC_FIXED_PRIO_EN
            rr_q         <= IW'(NREQ - 1);
`endif
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        owner_q  <= win_d;
                        we_q     <= req_we[win_d];
                        waddr_q  <= req_waddr[win_d*AW +: AW];
                        wdata_q  <= req_wdata[win_d*DW +: DW];
                        raddr1_q <= req_raddr1[win_d*AW +: AW];
                        raddr2_q <= req_raddr2[win_d*AW +: AW];
                        gnt_q    <= ONE << win_d;
                        busy_q   <= 1'b1;
`ifndef RBC_FIXED_PRIO_EN
                        rr_q     <= win_d;
`endif
                        state_q  <= S_ACCESS;
                    end
                end
                // Bank pins are registered here so the bank sees them during the following cycle.
                S_ACCESS: begin
                    if (we_q) begin
                        rb_w_r_q   <= 1'b1;
                        rb_w_add_q <= waddr_q;
                        rb_data_q  <= wdata_q;
                    end else begin
                        rb_w_r_q     <= 1'b0;
                        rb_r_add_1_q <= raddr1_q;
                        rb_r_add_2_q <= raddr2_q;
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (!we_q) begin
                        rdata1_q <= rb_data_1;
                        rdata2_q <= rb_data_2;
                    end
                    done_q   <= ONE << owner_q;
                    rb_w_r_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign rdata1     = rdata1_q;
    assign rdata2     = rdata2_q;
    assign busy       = busy_q;
    assign rb_w_r     = rb_w_r_q;
    assign rb_w_add   = rb_w_add_q;
    assign rb_r_add_1 = rb_r_add_1_q;
    assign rb_r_add_2 = rb_r_add_2_q;
    assign rb_data    = rb_data_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench for reg_bank_ctrl with a behavioural 16x8 register bank attached to the rb_* pins.
module tb_reg_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = '0;
    logic [1:0] req_we = '0;
    logic [7:0] req_waddr = '0;
    logic [15:0] req_wdata = '0;
    logic [7:0] req_raddr1 = '0;
    logic [7:0] req_raddr2 = '0;
    logic [1:0] gnt, done;
    logic [7:0] rdata1, rdata2;
    logic       busy, rb_w_r;
    logic [3:0] rb_w_add, rb_r_add_1, rb_r_add_2;
    logic [7:0] rb_data, rb_data_1, rb_data_2;

    int total = 0;
    int bad = 0;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    always @(posedge clk) if (rb_w_r) mem[rb_w_add] <= rb_data;
    assign rb_data_1 = mem[rb_r_add_1];
    assign rb_data_2 = mem[rb_r_add_2];

    reg_bank_ctrl #(.NREQ(2), .AW(4), .DW(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we),
        .req_waddr(req_waddr), .req_wdata(req_wdata),
        .req_raddr1(req_raddr1), .req_raddr2(req_raddr2),
        .gnt(gnt), .done(done), .rdata1(rdata1), .rdata2(rdata2), .busy(busy),
        .rb_w_r(rb_w_r), .rb_w_add(rb_w_add), .rb_r_add_1(rb_r_add_1),
        .rb_r_add_2(rb_r_add_2), .rb_data(rb_data),
        .rb_data_1(rb_data_1), .rb_data_2(rb_data_2)
    );

    task automatic set_fields(input int r, input logic we, input logic [3:0] wa,
                              input logic [7:0] wd, input logic [3:0] a1, input logic [3:0] a2);
        req_we[r]          = we;
        req_waddr[r*4 +: 4] = wa;
        req_wdata[r*8 +: 8] = wd;
        req_raddr1[r*4 +: 4] = a1;
        req_raddr2[r*4 +: 4] = a2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b want=00", gnt); end
        total++; if (done !== 2'b00) begin bad++; $display("FAIL rst_done got=%b want=00", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (rb_w_r !== 1'b0) begin bad++; $display("FAIL rst_rb_w_r got=%b want=0", rb_w_r); end
        total++; if (rdata1 !== 8'h00 || rdata2 !== 8'h00) begin
            bad++; $display("FAIL rst_rdata got=%h/%h want=00/00", rdata1, rdata2);
        end
        total++; if (rb_w_add !== 4'd0 || rb_data !== 8'h00) begin
            bad++; $display("FAIL rst_rb got=%h/%h want=0/00", rb_w_add, rb_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_write;
        @(negedge clk);
        set_fields(0, 1'b1, 4'd10, 8'h0A, 4'd0, 4'd0);
        req = 2'b01;
        @(negedge clk);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL wr_gnt got=%b want=01", gnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b want=1", busy); end
        req = 2'b00;
        @(negedge clk);
        total++; if (rb_w_r !== 1'b1 || rb_w_add !== 4'd10 || rb_data !== 8'h0A) begin
            bad++; $display("FAIL wr_bank got=%b/%0d/%h want=1/10/0a", rb_w_r, rb_w_add, rb_data);
        end
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL wr_gnt_pulse got=%b want=00", gnt); end
        @(negedge clk);
        total++; if (done !== 2'b01) begin bad++; $display("FAIL wr_done got=%b want=01", done); end
        total++; if (rb_w_r !== 1'b0) begin bad++; $display("FAIL wr_rb_w_r_low got=%b want=0", rb_w_r); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_read;
        set_fields(0, 1'b1, 4'd1, 8'h55, 4'd0, 4'd0);
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        total++; if (done !== 2'b01) begin bad++; $display("FAIL wr1_done got=%b want=01", done); end
        set_fields(1, 1'b0, 4'd0, 8'h00, 4'd10, 4'd1);
        req = 2'b10;
        @(negedge clk);
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rd_gnt got=%b want=10", gnt); end
        total++; if (rb_w_r !== 1'b0) begin bad++; $display("FAIL rd_w_r1 got=%b want=0", rb_w_r); end
        req = 2'b00;
        @(negedge clk);
        total++; if (rb_w_r !== 1'b0 || rb_r_add_1 !== 4'd10 || rb_r_add_2 !== 4'd1) begin
            bad++; $display("FAIL rd_bank got=%b/%0d/%0d want=0/10/1", rb_w_r, rb_r_add_1, rb_r_add_2);
        end
        total++; if (rb_w_add !== 4'd1 || rb_data !== 8'h55) begin
            bad++; $display("FAIL rd_hold got=%0d/%h want=1/55", rb_w_add, rb_data);
        end
        @(negedge clk);
        total++; if (done !== 2'b10) begin bad++; $display("FAIL rd_done got=%b want=10", done); end
        total++; if (rdata1 !== 8'h0A || rdata2 !== 8'h55) begin
            bad++; $display("FAIL rd_data got=%h/%h want=0a/55", rdata1, rdata2);
        end
        total++; if (rb_w_r !== 1'b0) begin bad++; $display("FAIL rd_w_r3 got=%b want=0", rb_w_r); end
    endtask

    task automatic test_arbitration;
        logic [1:0] exp_order [4];
        int t;
        int w;
`ifdef RBC_FIXED_PRIO_EN
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        set_fields(0, 1'b0, 4'd0, 8'h00, 4'd10, 4'd1);
        set_fields(1, 1'b0, 4'd0, 8'h00, 4'd1, 4'd10);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            @(negedge clk);
            while (gnt === 2'b00 && t < 6) begin
                @(negedge clk);
                t++;
            end
            total++;
            if (gnt !== exp_order[k]) begin
                bad++; $display("FAIL arb_gnt%0d got=%b want=%b", k, gnt, exp_order[k]);
            end
            w = (gnt === 2'b10) ? 1 : 0;
            req[w] = 1'b0;
            t = 0;
            @(negedge clk);
            while (done === 2'b00 && t < 6) begin
                @(negedge clk);
                t++;
            end
            total++;
            if (done !== exp_order[k]) begin
                bad++; $display("FAIL arb_done%0d got=%b want=%b", k, done, exp_order[k]);
            end
            req[w] = 1'b1;
        end
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        set_fields(1, 1'b0, 4'd0, 8'h00, 4'd1, 4'd10);
        req = 2'b10;
        @(negedge clk);
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rm_gnt got=%b want=10", gnt); end
        req = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0 || done !== 2'b00 || rb_w_r !== 1'b0) begin
            bad++; $display("FAIL rm_idle got=busy%b done%b w_r%b want=busy0 done00 w_r0", busy, done, rb_w_r);
        end
        total++; if (rdata1 !== 8'h00) begin bad++; $display("FAIL rm_rdata got=%h want=00", rdata1); end
        @(negedge clk);
        total++; if (done !== 2'b00) begin bad++; $display("FAIL rm_nodone got=%b want=00", done); end
        set_fields(1, 1'b0, 4'd0, 8'h00, 4'd10, 4'd1);
        req = 2'b10;
        @(negedge clk);
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rm_regnt got=%b want=10", gnt); end
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        total++; if (done !== 2'b10 || rdata1 !== 8'h0A || rdata2 !== 8'h55) begin
            bad++; $display("FAIL rm_redone got=%b/%h/%h want=10/0a/55", done, rdata1, rdata2);
        end
    endtask

    task automatic test_back_to_back;
        set_fields(0, 1'b1, 4'd3, 8'hC3, 4'd0, 4'd0);
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        total++; if (done !== 2'b01) begin bad++; $display("FAIL b2b_wdone got=%b want=01", done); end
        set_fields(0, 1'b0, 4'd0, 8'h00, 4'd3, 4'd10);
        req = 2'b01;
        @(negedge clk);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL b2b_gnt got=%b want=01", gnt); end
        req = 2'b00;
        @(negedge clk);
        total++; if (rb_w_r !== 1'b0) begin bad++; $display("FAIL b2b_w_r got=%b want=0", rb_w_r); end
        @(negedge clk);
        total++; if (done !== 2'b01 || rdata1 !== 8'hC3 || rdata2 !== 8'h0A) begin
            bad++; $display("FAIL b2b_rdata got=%b/%h/%h want=01/c3/0a", done, rdata1, rdata2);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
